nand_add_sub_unit: RTL and testbench

- Registered adder/subtractor whose combinational core is built only from 2-input NAND cells, one full-adder/full-subtractor slice per bit, rippled LSB to MSB.
- With WIDTH=1 and op=00 it is a clocked single-bit full adder (sum, carry).
- Used as the arithmetic leaf in the gate-level datapath exercises.
- Results are registered with one cycle of latency.

---
 rtl/nand_add_sub_unit.sv | 107 ++++++++++
 tb/tb_nand_add_sub_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nand_add_sub_unit.sv
// Registered ripple adder/subtractor built only from 2-input NAND cells; 1-cycle latency.
// No backpressure: every edge with in_valid high captures an independent result.

module nand_add_sub_nand2 (
   input  logic x_i,
   input  logic y_i,
   output logic z_o
);
   assign z_o = ~(x_i & y_i);
endmodule

module nand_add_sub_xor2 (
   input  logic x_i,
   input  logic y_i,
   output logic z_o
);
   logic n1, n2, n3;
   nand_add_sub_nand2 u_n1 (.x_i(x_i), .y_i(y_i), .z_o(n1));
   nand_add_sub_nand2 u_n2 (.x_i(x_i), .y_i(n1),  .z_o(n2));
   nand_add_sub_nand2 u_n3 (.x_i(y_i), .y_i(n1),  .z_o(n3));
   nand_add_sub_nand2 u_n4 (.x_i(n2),  .y_i(n3),  .z_o(z_o));
endmodule

// One add/subtract bit: the carry terms see a or ~a, which turns the
// majority carry into the borrow expression without touching the sum path.
module nand_add_sub_slice (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   input  logic sub_i,
   input  logic nsub_i,
   output logic s_o,
   output logic co_o
);
   logic ab_x, a_n, sel_t1, sel_t0, a_c, p, g_n, t_n;

   nand_add_sub_xor2  u_xab (.x_i(a_i),  .y_i(b_i),  .z_o(ab_x));
   nand_add_sub_xor2  u_xs  (.x_i(ab_x), .y_i(ci_i), .z_o(s_o));

   nand_add_sub_nand2 u_inv (.x_i(a_i),    .y_i(a_i),    .z_o(a_n));
   nand_add_sub_nand2 u_m1  (.x_i(a_n),    .y_i(sub_i),  .z_o(sel_t1));
   nand_add_sub_nand2 u_m0  (.x_i(a_i),    .y_i(nsub_i), .z_o(sel_t0));
   nand_add_sub_nand2 u_mo  (.x_i(sel_t0), .y_i(sel_t1), .z_o(a_c));

   nand_add_sub_xor2  u_xp  (.x_i(a_c), .y_i(b_i),  .z_o(p));
   nand_add_sub_nand2 u_g   (.x_i(a_c), .y_i(b_i),  .z_o(g_n));
   nand_add_sub_nand2 u_t   (.x_i(p),   .y_i(ci_i), .z_o(t_n));
   nand_add_sub_nand2 u_co  (.x_i(g_n), .y_i(t_n),  .z_o(co_o));
endmodule

module nand_add_sub_unit #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid
);
   logic             nsub, nhalf, cin_n;
   logic [WIDTH:0]   rip;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             carry_d, carry_q, out_valid_q;

   nand_add_sub_nand2 u_nsub  (.x_i(op[0]), .y_i(op[0]), .z_o(nsub));
   nand_add_sub_nand2 u_nhalf (.x_i(op[1]), .y_i(op[1]), .z_o(nhalf));
   // Half modes gate the external carry/borrow off at bit 0 only.
   nand_add_sub_nand2 u_cin_n (.x_i(c),     .y_i(nhalf), .z_o(cin_n));
   nand_add_sub_nand2 u_cin   (.x_i(cin_n), .y_i(cin_n), .z_o(rip[0]));

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nand_add_sub_slice u_slice (
         .a_i   (a[i]),
         .b_i   (b[i]),
         .ci_i  (rip[i]),
         .sub_i (op[0]),
         .nsub_i(nsub),
         .s_o   (sum_d[i]),
         .co_o  (rip[i+1])
      );
   end

   assign carry_d = rip[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
         end
      end
   end

   assign sum       = sum_q;
   assign carry     = carry_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_nand_add_sub_unit.sv
// Bench for nand_add_sub_unit at widths 1, 4 and 16 sharing one operand bus.
module tb_nand_add_sub_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   logic        c = 1'b0;

   logic [0:0]  s1;
   logic [3:0]  s4;
   logic [15:0] s16;
   logic        c1, c4, c16, v1, v4, v16;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nand_add_sub_unit #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
      .a(a_in[0:0]), .b(b_in[0:0]), .c(c),
      .sum(s1), .carry(c1), .out_valid(v1));

   nand_add_sub_unit #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
      .a(a_in[3:0]), .b(b_in[3:0]), .c(c),
      .sum(s4), .carry(c4), .out_valid(v4));

   nand_add_sub_unit #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
      .a(a_in), .b(b_in), .c(c),
      .sum(s16), .carry(c16), .out_valid(v16));

   typedef struct {
      int          w;
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] es;
      logic        ec;
   } vec_t;

   vec_t vecs[$];

   int          widths[3] = '{1, 4, 16};
   logic [15:0] hold_s[3];
   logic        hold_c[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic get_out(input int w, output logic [15:0] s, output logic cy, output logic v);
      case (w)
         1:       begin s = {15'd0, s1}; cy = c1;  v = v1;  end
         4:       begin s = {12'd0, s4}; cy = c4;  v = v4;  end
         default: begin s = s16;         cy = c16; v = v16; end
      endcase
   endtask

   task automatic chk_w(input string name, input int w, input logic [15:0] es,
                        input logic ec, input logic ev);
      logic [15:0] s;
      logic        cy, v;
      get_out(w, s, cy, v);
      chk($sformatf("%s w%0d sum", name, w), {16'd0, s}, {16'd0, es});
      chk($sformatf("%s w%0d carry", name, w), {31'd0, cy}, {31'd0, ec});
      chk($sformatf("%s w%0d valid", name, w), {31'd0, v}, {31'd0, ev});
   endtask

   // Arithmetic reference: {carry, sum} for width w.
   function automatic logic [16:0] model(input int w, input logic [1:0] o,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic ci);
      longint unsigned mask, av, bv, cv, r;
      logic            cy;
      mask = (64'd1 << w) - 1;
      av   = a & mask;
      bv   = b & mask;
      cv   = (o[1]) ? 0 : {63'd0, ci};
      if (!o[0]) begin
         r  = av + bv + cv;
         cy = r[w];
      end else begin
         r  = av - bv - cv;
         cy = (av < bv + cv);
      end
      r = r & mask;
      return {cy, r[15:0]};
   endfunction

   task automatic drive(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic iv);
      @(negedge clk);
      op = o; a_in = a; b_in = b; c = ci; in_valid = iv;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(int w, logic [1:0] o, logic [15:0] a, logic [15:0] b,
                               logic ci, logic [15:0] es, logic ec);
      vec_t v;
      v.w = w; v.op = o; v.a = a; v.b = b; v.c = ci; v.es = es; v.ec = ec;
      return v;
   endfunction

   initial begin
      logic [2:0]  abc;
      logic [7:0]  add_tab;
      logic [7:0]  add_cy;
      logic [7:0]  sub_tab;
      logic [7:0]  sub_cy;
      logic [16:0] m;

      // Truth tables indexed by abc, expected (sum,carry) pairs from the spec.
      add_tab = 8'b1001_0110;  add_cy = 8'b1110_1000;
      sub_tab = 8'b1001_0110;  sub_cy = 8'b1000_1110;
      for (int i = 0; i < 8; i++) begin
         abc = i[2:0];
         vecs.push_back(mk(1, 2'b00, {15'd0, abc[2]}, {15'd0, abc[1]}, abc[0],
                           {15'd0, add_tab[i]}, add_cy[i]));
      end
      for (int i = 0; i < 8; i++) begin
         abc = i[2:0];
         vecs.push_back(mk(1, 2'b01, {15'd0, abc[2]}, {15'd0, abc[1]}, abc[0],
                           {15'd0, sub_tab[i]}, sub_cy[i]));
      end
      vecs.push_back(mk(1, 2'b10, 16'h1, 16'h1, 1'b1, 16'h0, 1'b1));
      vecs.push_back(mk(1, 2'b11, 16'h0, 16'h1, 1'b1, 16'h1, 1'b1));
      vecs.push_back(mk(4, 2'b00, 16'hF, 16'hF, 1'b1, 16'hF, 1'b1));
      vecs.push_back(mk(4, 2'b01, 16'h3, 16'h5, 1'b0, 16'hE, 1'b1));
      vecs.push_back(mk(4, 2'b01, 16'h9, 16'h4, 1'b1, 16'h4, 1'b0));
      vecs.push_back(mk(16, 2'b00, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1));
      vecs.push_back(mk(16, 2'b01, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1));
      vecs.push_back(mk(4, 2'b11, 16'h0, 16'h0, 1'b1, 16'h0, 1'b0));

      // Reset holds outputs at zero even with valid operands present.
      op = 2'b00; a_in = 16'h1; b_in = 16'h1; c = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk_w("reset", 1, 16'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_w("first_capture", 1, 16'h1, 1'b1, 1'b1);

      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
         chk_w($sformatf("vec%0d", i), vecs[i].w, vecs[i].es, vecs[i].ec, 1'b1);
      end

      // Idle: results hold, qualifier drops.
      drive(2'b00, 16'h0007, 16'h0005, 1'b1, 1'b1);
      chk_w("pre_idle", 4, 16'hD, 1'b0, 1'b1);
      drive(2'b01, 16'h0000, 16'h0000, 1'b1, 1'b0);
      chk_w("idle_hold", 4, 16'hD, 1'b0, 1'b0);

      // Op change between edges does not disturb the registered result.
      drive(2'b00, 16'h0008, 16'h0008, 1'b0, 1'b1);
      chk_w("op_pre", 4, 16'h0, 1'b1, 1'b1);
      op = 2'b01;
      #2;
      chk_w("op_between", 4, 16'h0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk_w("op_next", 4, 16'h0, 1'b0, 1'b1);

      // Asynchronous clear between edges.
      drive(2'b00, 16'h00FF, 16'h0001, 1'b1, 1'b1);
      chk_w("pre_arst", 16, 16'h0101, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_w("arst", 16, 16'h0, 1'b0, 1'b0);
      chk_w("arst", 1, 16'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         hold_s[k] = '0;
         hold_c[k] = 1'b0;
      end

      // Randomized back-to-back traffic with random idle cycles.
      for (int n = 0; n < 300; n++) begin
         logic [1:0]  ro;
         logic [15:0] ra, rb;
         logic        rc, rv;
         ro = 2'($urandom_range(0, 3));
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         if (n % 37 == 0) begin ra = 16'hFFFF; rb = (n % 2 == 0) ? 16'hFFFF : 16'h0; end
         drive(ro, ra, rb, rc, rv);
         for (int k = 0; k < 3; k++) begin
            if (rv) begin
               m = model(widths[k], ro, ra, rb, rc);
               hold_s[k] = m[15:0];
               hold_c[k] = m[16];
            end
            chk_w($sformatf("rnd%0d", n), widths[k], hold_s[k], hold_c[k], rv);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
